// File: rtl/tea_io_port.sv
// tea_io_port: IO-bus responder for tea_cpu. Carries a host->CPU byte stream
// through an RX FIFO and a CPU->host byte stream through a TX FIFO. It also
// provides status and level registers and sticky underflow/overflow flags.
module tea_io_port #(
  parameter int unsigned FIFO_AW = 3,
  parameter logic [4:0]  IO_BASE = 5'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] io_addr,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_wrdata,
  output logic [7:0] io_rddata,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef logic [FIFO_AW:0] ptr_t;

  // Access-phase flag: high during the 2nd cycle of each 2-cycle strobe.
  logic hf_q, hf_d;

  logic [7:0] rx_mem_q [Depth];
  logic [7:0] rx_mem_d [Depth];
  logic [7:0] tx_mem_q [Depth];
  logic [7:0] tx_mem_d [Depth];
  ptr_t       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  ptr_t       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic       rx_udf_q, rx_udf_d;
  logic       tx_ovf_q, tx_ovf_d;

  logic [4:0] off;
  logic       fire_rd, fire_wr;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  ptr_t       rx_level, tx_level;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic       udf_set, ovf_set, udf_clr, ovf_clr;
  logic [7:0] status;

  assign off     = io_addr - IO_BASE;
  assign fire_rd = io_rd && hf_q;
  assign fire_wr = io_wr && hf_q;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                    (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                    (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
  assign rx_level = rx_wr_q - rx_rd_q;
  assign tx_level = tx_wr_q - tx_rd_q;

  assign host_rx_ready = !rx_full;
  assign host_tx_valid = !tx_empty;
  assign host_tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q[FIFO_AW-1:0]];

  assign status = {2'b00, tx_ovf_q, rx_udf_q, tx_full, tx_empty, rx_full, rx_empty};

  // Event decode; FIFO full/empty are the values before this cycle's updates.
  always_comb begin
    rx_push = host_rx_valid && !rx_full;
    tx_pop  = !tx_empty && host_tx_ready;
    rx_pop  = fire_rd && (off == 5'd0) && !rx_empty;
    udf_set = fire_rd && (off == 5'd0) && rx_empty;
    tx_push = fire_wr && (off == 5'd1) && !tx_full;
    ovf_set = fire_wr && (off == 5'd1) && tx_full;
    udf_clr = fire_wr && (off == 5'd2) && io_wrdata[4];
    ovf_clr = fire_wr && (off == 5'd2) && io_wrdata[5];
  end

  // Next-state for phase flag, FIFOs and sticky flags.
  always_comb begin
    hf_d     = (io_rd || io_wr) ? !hf_q : 1'b0;
    rx_mem_d = rx_mem_q;
    tx_mem_d = tx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q[FIFO_AW-1:0]] = host_rx_data;
      rx_wr_d = rx_wr_q + ptr_t'(1);
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + ptr_t'(1);
    end
    if (tx_push) begin
      tx_mem_d[tx_wr_q[FIFO_AW-1:0]] = io_wrdata;
      tx_wr_d = tx_wr_q + ptr_t'(1);
    end
    if (tx_pop) begin
      tx_rd_d = tx_rd_q + ptr_t'(1);
    end
    // Set wins over a simultaneous W1C.
    rx_udf_d = (rx_udf_q && !udf_clr) || udf_set;
    tx_ovf_d = (tx_ovf_q && !ovf_clr) || ovf_set;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hf_q     <= 1'b0;
      rx_mem_q <= '{default: '0};
      tx_mem_q <= '{default: '0};
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_udf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      hf_q     <= hf_d;
      rx_mem_q <= rx_mem_d;
      tx_mem_q <= tx_mem_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_udf_q <= rx_udf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  // Read mux; holds steady across both cycles of a read since pops land after the 2nd edge.
  always_comb begin
    io_rddata = 8'h00;
    if (io_rd) begin
      case (off)
        5'd0:    io_rddata = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[FIFO_AW-1:0]];
        5'd2:    io_rddata = status;
        5'd3:    io_rddata = 8'(rx_level);
        5'd4:    io_rddata = 8'(tx_level);
        default: io_rddata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_io_port.sv
// Bench for tea_io_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tea_io_port;

  localparam logic [4:0] IO_BASE = 5'h00;
  localparam int         DEPTH   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] io_addr;
  logic       io_rd, io_wr;
  logic [7:0] io_wrdata, io_rddata;
  logic [7:0] host_rx_data, host_tx_data;
  logic       host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;

  always #5 clk = ~clk;

  tea_io_port #(
    .FIFO_AW(3),
    .IO_BASE(IO_BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_addr      (io_addr),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .io_wrdata    (io_wrdata),
    .io_rddata    (io_rddata),
    .host_rx_data (host_rx_data),
    .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .host_tx_data (host_tx_data),
    .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit rnd_done = 1'b0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_uf, m_of;
  int         run;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {2'b00, m_of, m_uf, txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() == 0};
  endfunction

  function automatic logic [7:0] exp_rddata();
    logic [4:0] off;
    off = io_addr - IO_BASE;
    if (!io_rd) return 8'h00;
    case (off)
      5'd0:    return (rxq.size() != 0) ? rxq[0] : 8'h00;
      5'd2:    return m_status();
      5'd3:    return 8'(rxq.size());
      5'd4:    return 8'(txq.size());
      default: return 8'h00;
    endcase
  endfunction

  // Model update on each rising edge from the inputs present at that edge.
  task automatic model_step();
    logic [4:0] off;
    bit strobe, fire, rxf, rxe, txf, txe, su, so, cu, co;
    off    = io_addr - IO_BASE;
    strobe = io_rd || io_wr;
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_uf = 0;
      m_of = 0;
      run  = 0;
      return;
    end
    fire = strobe && (run % 2 == 1);
    run  = strobe ? run + 1 : 0;
    rxf  = (rxq.size() == DEPTH);
    rxe  = (rxq.size() == 0);
    txf  = (txq.size() == DEPTH);
    txe  = (txq.size() == 0);
    su = 0; so = 0; cu = 0; co = 0;
    if (fire && io_rd && off == 5'd0) begin
      if (rxe) su = 1;
      else void'(rxq.pop_front());
    end
    if (host_rx_valid && !rxf) rxq.push_back(host_rx_data);
    if (!txe && host_tx_ready) void'(txq.pop_front());
    if (fire && io_wr && off == 5'd1) begin
      if (txf) so = 1;
      else txq.push_back(io_wrdata);
    end
    if (fire && io_wr && off == 5'd2) begin
      cu = io_wrdata[4];
      co = io_wrdata[5];
    end
    m_uf = (m_uf && !cu) || su;
    m_of = (m_of && !co) || so;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every DUT output against the model once per cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check8("io_rddata", io_rddata, exp_rddata());
      check8("host_rx_ready", 8'(host_rx_ready), 8'(rxq.size() < DEPTH));
      check8("host_tx_valid", 8'(host_tx_valid), 8'(txq.size() != 0));
      check8("host_tx_data", host_tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input bit rd, input logic [4:0] a, input logic [7:0] w,
                            input int cycles, output logic [7:0] d);
    step();
    io_addr   = a;
    io_wrdata = w;
    if (rd) io_rd = 1'b1;
    else io_wr = 1'b1;
    step();
    @(negedge clk);
    d = io_rddata;
    repeat (cycles - 1) step();
    io_rd = 1'b0;
    io_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [7:0] d);
    cpu_access(1'b1, a, 8'h00, 2, d);
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] w);
    logic [7:0] unused;
    cpu_access(1'b0, a, w, 2, unused);
  endtask

  task automatic host_push(input logic [7:0] b);
    step();
    host_rx_data  = b;
    host_rx_valid = 1'b1;
    step();
    host_rx_valid = 1'b0;
  endtask

  logic [7:0] d;
  logic [7:0] got[$];

  initial begin
    rst = 1'b1; io_addr = '0; io_rd = 0; io_wr = 0; io_wrdata = '0;
    host_rx_data = '0; host_rx_valid = 0; host_tx_ready = 0;
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check8("reset rddata", io_rddata, 8'h00);
    check8("reset rx_ready", 8'(host_rx_ready), 8'h01);
    check8("reset tx_valid", 8'(host_tx_valid), 8'h00);
    check8("reset tx_data", host_tx_data, 8'h00);
    cpu_read(IO_BASE + 5'd2, d); check8("reset status", d, 8'h05);

    // Basic RX path
    host_push(8'h12);
    host_push(8'h34);
    cpu_read(IO_BASE + 5'd3, d); check8("rx level 2", d, 8'h02);
    cpu_read(IO_BASE + 5'd0, d); check8("rx data 0x12", d, 8'h12);
    cpu_read(IO_BASE + 5'd0, d); check8("rx data 0x34", d, 8'h34);
    cpu_read(IO_BASE + 5'd2, d); check8("status empty", d, 8'h05);

    // Underflow and W1C
    cpu_read(IO_BASE + 5'd0, d); check8("underflow data", d, 8'h00);
    cpu_read(IO_BASE + 5'd2, d); check8("underflow status", d, 8'h15);
    cpu_write(IO_BASE + 5'd2, 8'h10);
    cpu_read(IO_BASE + 5'd2, d); check8("w1c status", d, 8'h05);

    // TX overflow; one RX byte parked so rx_empty is clear in STATUS
    host_push(8'h55);
    for (int i = 0; i < 9; i++) cpu_write(IO_BASE + 5'd1, 8'(8'hA0 + i));
    cpu_read(IO_BASE + 5'd4, d); check8("tx level 8", d, 8'h08);
    cpu_read(IO_BASE + 5'd2, d); check8("overflow status", d, 8'h28);
    step();
    host_tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (host_tx_valid) got.push_back(host_tx_data);
      step();
    end
    host_tx_ready = 1'b0;
    check8("drain count", 8'(got.size()), 8'h08);
    for (int i = 0; i < 8; i++)
      check8("drain byte", (i < got.size()) ? got[i] : 8'h00, 8'(8'hA0 + i));
    cpu_read(IO_BASE + 5'd0, d); check8("parked rx byte", d, 8'h55);
    cpu_write(IO_BASE + 5'd2, 8'h20);
    cpu_read(IO_BASE + 5'd2, d); check8("ovf cleared", d, 8'h05);

    // 4-cycle strobe is two accesses
    host_push(8'h01); host_push(8'h02); host_push(8'h03);
    step();
    io_addr = IO_BASE; io_rd = 1'b1;
    step(); step(); step();
    @(negedge clk);
    check8("hold4 2nd data", io_rddata, 8'h02);
    step();
    io_rd = 1'b0;
    cpu_read(IO_BASE + 5'd3, d); check8("hold4 level", d, 8'h01);
    cpu_read(IO_BASE + 5'd0, d); check8("hold4 leftover", d, 8'h03);

    // Simultaneous host push and CPU pop at level 7
    for (int i = 0; i < 7; i++) host_push(8'(8'h70 + i));
    cpu_read(IO_BASE + 5'd3, d); check8("level 7", d, 8'h07);
    step();
    io_addr = IO_BASE; io_rd = 1'b1;
    step();
    host_rx_data = 8'h77; host_rx_valid = 1'b1;
    step();
    io_rd = 1'b0; host_rx_valid = 1'b0;
    @(negedge clk);
    check8("push+pop ready", 8'(host_rx_ready), 8'h01);
    cpu_read(IO_BASE + 5'd3, d); check8("push+pop level", d, 8'h07);
    host_push(8'h78);
    @(negedge clk);
    check8("full ready", 8'(host_rx_ready), 8'h00);
    cpu_read(IO_BASE + 5'd3, d); check8("level 8", d, 8'h08);

    // Reset during the 1st cycle of a DATA read
    step();
    io_addr = IO_BASE; io_rd = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    io_rd = 1'b0;
    cpu_read(IO_BASE + 5'd3, d); check8("post-reset level", d, 8'h00);
    cpu_read(IO_BASE + 5'd2, d); check8("post-reset status", d, 8'h05);

    // Randomized traffic against the model
    fork
      begin
        while (!rnd_done) begin
          step();
          host_rx_valid = 1'($urandom_range(0, 1));
          host_rx_data  = 8'($urandom);
          host_tx_ready = ($urandom_range(0, 3) == 0);
        end
      end
      begin
        for (int n = 0; n < 400; n++) begin
          int kind;
          logic [4:0] a;
          kind = int'($urandom_range(0, 9));
          a = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
          if (kind == 0) begin
            step();
          end else if (kind == 1 && $urandom_range(0, 9) == 0) begin
            step(); rst = 1'b1; step(); rst = 1'b0;
          end else begin
            cpu_access(kind < 5, a, 8'($urandom), ($urandom_range(0, 4) == 0) ? 4 : 2, d);
          end
        end
        rnd_done = 1'b1;
      end
    join
    step();
    host_rx_valid = 1'b0;
    host_tx_ready = 1'b0;
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
